// File: rtl/resend_q.sv
// Synchronous first-word-fall-through queue for ring resend slots and capture FIFOs.
// The head entry is presented combinationally on dout; a pop takes effect at the next edge.
module resend_q #(
    parameter int WIDTH   = 40,
    parameter int LOGSIZE = 9
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [WIDTH-1:0]   din,
    input  logic               wr_en,
    input  logic               rd_en,
    output logic [WIDTH-1:0]   dout,
    output logic               empty,
    output logic               full,
    output logic [LOGSIZE:0]   count,
    output logic               overflow,
    output logic               underflow
);

    localparam int               DEPTH      = 1 << LOGSIZE;
    localparam logic [LOGSIZE:0] FULL_COUNT = (LOGSIZE + 1)'(DEPTH);
    localparam logic [LOGSIZE:0] COUNT_ONE  = (LOGSIZE + 1)'(1);
    localparam logic [LOGSIZE-1:0] PTR_ONE  = LOGSIZE'(1);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [LOGSIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOGSIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOGSIZE:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
    logic               wr_acc;
    logic               rd_acc;

    // Flags come only from the registered count, so wr_en never reaches them combinationally.
    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_COUNT);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign dout      = empty ? '0 : mem[rd_ptr_q];

    // A full queue still accepts a write when the head is popped in the same cycle.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_en);

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        overflow_d  = wr_en & ~wr_acc;
        underflow_d = rd_en & empty;
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never cleared; reset only blocks a simultaneous write.
    always_ff @(posedge clock) begin
        if (!reset && wr_acc) begin
            mem[wr_ptr_q] <= din;
        end
    end

endmodule

// File: tb/tb_resend_q.sv
// Self-checking bench for resend_q at LOGSIZE=2: a cycle table of expected flags
// plus a reference queue that checks the head value on every accepted pop.
module tb_resend_q;

    localparam int WIDTH   = 40;
    localparam int LOGSIZE = 2;
    localparam int DEPTH   = 1 << LOGSIZE;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic [WIDTH-1:0]   din = '0;
    logic               wr_en = 1'b0;
    logic               rd_en = 1'b0;
    logic [WIDTH-1:0]   dout;
    logic               empty;
    logic               full;
    logic [LOGSIZE:0]   count;
    logic               overflow;
    logic               underflow;

    resend_q #(.WIDTH(WIDTH), .LOGSIZE(LOGSIZE)) dut (
        .clock     (clock),
        .reset     (reset),
        .din       (din),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .dout      (dout),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic             rst;
        logic             wr;
        logic             rd;
        logic [WIDTH-1:0] data;
        logic             eEmpty;
        logic             eFull;
        logic [LOGSIZE:0] eCount;
        logic             eOvf;
        logic             eUnf;
        logic [WIDTH-1:0] eDout;
    } vec_t;

    vec_t             vecs[$];
    logic [WIDTH-1:0] model[$];
    int               checks = 0;
    int               errors = 0;

    task automatic addVec(input logic rst, input logic wr, input logic rd, input logic [WIDTH-1:0] data,
                          input logic eEmpty, input logic eFull, input int eCount,
                          input logic eOvf, input logic eUnf, input logic [WIDTH-1:0] eDout);
        vec_t v;
        v.rst    = rst;
        v.wr     = wr;
        v.rd     = rd;
        v.data   = data;
        v.eEmpty = eEmpty;
        v.eFull  = eFull;
        v.eCount = (LOGSIZE + 1)'(eCount);
        v.eOvf   = eOvf;
        v.eUnf   = eUnf;
        v.eDout  = eDout;
        vecs.push_back(v);
    endtask

    task automatic compare(input string name, input int row, input logic [WIDTH-1:0] got,
                           input logic [WIDTH-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL row %0d %s: got %0h expected %0h", row, name, got, want);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and let the reference queue
    // check the head value for any pop that the queue must accept.
    task automatic applyStimulus(input int row);
        logic canPop;
        logic canPush;
        logic [WIDTH-1:0] head;
        @(negedge clock);
        reset = vecs[row].rst;
        wr_en = vecs[row].wr;
        rd_en = vecs[row].rd;
        din   = vecs[row].data;
        if (vecs[row].rst) begin
            model.delete();
        end else begin
            canPop  = vecs[row].rd && (model.size() > 0);
            canPush = vecs[row].wr && ((model.size() < DEPTH) || canPop);
            if (canPop) begin
                head = model.pop_front();
                compare("popHead", row, dout, head);
            end
            if (canPush) begin
                model.push_back(vecs[row].data);
            end
        end
    endtask

    task automatic checkOutput(input int row);
        @(posedge clock);
        #1;
        compare("empty",     row, WIDTH'(empty),     WIDTH'(vecs[row].eEmpty));
        compare("full",      row, WIDTH'(full),      WIDTH'(vecs[row].eFull));
        compare("count",     row, WIDTH'(count),     WIDTH'(vecs[row].eCount));
        compare("overflow",  row, WIDTH'(overflow),  WIDTH'(vecs[row].eOvf));
        compare("underflow", row, WIDTH'(underflow), WIDTH'(vecs[row].eUnf));
        compare("dout",      row, dout,              vecs[row].eDout);
        compare("modelSize", row, WIDTH'(count),     WIDTH'(model.size()));
    endtask

    initial begin
        //     rst wr rd din           empty full cnt ovf unf dout
        // Two-cycle reset; the second cycle also tries to write and read.
        addVec(1, 0, 0, 40'h0,          1, 0, 0, 0, 0, 40'h0);
        addVec(1, 1, 1, 40'h55,         1, 0, 0, 0, 0, 40'h0);
        // FWFT: written entry is visible right after the edge.
        addVec(0, 1, 0, 40'hA60000123,  0, 0, 1, 0, 0, 40'hA60000123);
        addVec(0, 0, 1, 40'h0,          1, 0, 0, 0, 0, 40'h0);
        // Fill, drop a write while full, drain in order.
        addVec(0, 1, 0, 40'd1,          0, 0, 1, 0, 0, 40'd1);
        addVec(0, 1, 0, 40'd2,          0, 0, 2, 0, 0, 40'd1);
        addVec(0, 1, 0, 40'd3,          0, 0, 3, 0, 0, 40'd1);
        addVec(0, 1, 0, 40'd4,          0, 1, 4, 0, 0, 40'd1);
        addVec(0, 1, 0, 40'd5,          0, 1, 4, 1, 0, 40'd1);
        addVec(0, 0, 0, 40'd0,          0, 1, 4, 0, 0, 40'd1);
        addVec(0, 0, 1, 40'd0,          0, 0, 3, 0, 0, 40'd2);
        addVec(0, 0, 1, 40'd0,          0, 0, 2, 0, 0, 40'd3);
        addVec(0, 0, 1, 40'd0,          0, 0, 1, 0, 0, 40'd4);
        addVec(0, 0, 1, 40'd0,          1, 0, 0, 0, 0, 40'd0);
        // Streaming write/pop pairs walk the pointers through the wrap.
        addVec(0, 1, 0, 40'd10,         0, 0, 1, 0, 0, 40'd10);
        addVec(0, 1, 1, 40'd11,         0, 0, 1, 0, 0, 40'd11);
        addVec(0, 1, 1, 40'd12,         0, 0, 1, 0, 0, 40'd12);
        addVec(0, 1, 1, 40'd13,         0, 0, 1, 0, 0, 40'd13);
        addVec(0, 1, 1, 40'd14,         0, 0, 1, 0, 0, 40'd14);
        addVec(0, 1, 1, 40'd15,         0, 0, 1, 0, 0, 40'd15);
        addVec(0, 0, 1, 40'd0,          1, 0, 0, 0, 0, 40'd0);
        // Full with simultaneous pop and write: both happen, 9 comes out last.
        addVec(0, 1, 0, 40'd21,         0, 0, 1, 0, 0, 40'd21);
        addVec(0, 1, 0, 40'd22,         0, 0, 2, 0, 0, 40'd21);
        addVec(0, 1, 0, 40'd23,         0, 0, 3, 0, 0, 40'd21);
        addVec(0, 1, 0, 40'd24,         0, 1, 4, 0, 0, 40'd21);
        addVec(0, 1, 1, 40'd9,          0, 1, 4, 0, 0, 40'd22);
        addVec(0, 0, 1, 40'd0,          0, 0, 3, 0, 0, 40'd23);
        addVec(0, 0, 1, 40'd0,          0, 0, 2, 0, 0, 40'd24);
        addVec(0, 0, 1, 40'd0,          0, 0, 1, 0, 0, 40'd9);
        addVec(0, 0, 1, 40'd0,          1, 0, 0, 0, 0, 40'd0);
        // Read while empty with a write: read ignored, write lands.
        addVec(0, 1, 1, 40'd7,          0, 0, 1, 0, 1, 40'd7);
        addVec(0, 0, 0, 40'd0,          0, 0, 1, 0, 0, 40'd7);
        addVec(0, 0, 1, 40'd0,          1, 0, 0, 0, 0, 40'd0);
        addVec(0, 0, 1, 40'd0,          1, 0, 0, 0, 1, 40'd0);
        addVec(0, 0, 0, 40'd0,          1, 0, 0, 0, 0, 40'd0);
        // Reset mid-stream discards held entries and the simultaneous write.
        addVec(0, 1, 0, 40'd31,         0, 0, 1, 0, 0, 40'd31);
        addVec(0, 1, 0, 40'd32,         0, 0, 2, 0, 0, 40'd31);
        addVec(0, 1, 0, 40'd33,         0, 0, 3, 0, 0, 40'd31);
        addVec(1, 1, 0, 40'd34,         1, 0, 0, 0, 0, 40'd0);
        addVec(0, 0, 0, 40'd0,          1, 0, 0, 0, 0, 40'd0);
        addVec(0, 1, 0, 40'd35,         0, 0, 1, 0, 0, 40'd35);
        addVec(0, 0, 1, 40'd0,          1, 0, 0, 0, 0, 40'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(i);
            checkOutput(i);
        end

        @(negedge clock);
        reset = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
